spi_frame_scheduler: RTL and testbench
======================================

// Module: spi_frame_scheduler
// PURPOSE
//  Sequences the SPI byte sender to ship one measurement result as a framed packet.
//  Accepts a DATA_BYTES-wide result via a valid/ready handshake, then emits HEADER, the data bytes MSB-first and an optional XOR checksum.
//  Each byte is a strobe pulse to the sender; its busy flag marks start and end of the byte.
//  Sits between the frequency-count result register and the byte-level SPI sender.
// PARAMETERS
//  DATA_BYTES     4        payload bytes per frame (1..8)
//  HEADER         8'hA5    first byte of every frame
//  STROBE_CYCLES  2        clk cycles byte_strobe is held high (>=2, so the sender's edge detector sees it)
//  BUSY_TIMEOUT   1023     max clk cycles to wait for byte_busy to rise, or to fall
//  GAP_CYCLES     16       idle clk cycles between bytes, after busy falls
// PORTS
//  clk          in   1               system clock
//  reset        in   1               async, active-high
//  meas_valid   in   1               result available
//  meas_data    in   8*DATA_BYTES    result, byte DATA_BYTES-1 sent first
//  meas_ready   out  1               block can accept a result (high only in IDLE)
//  byte_data    out  8               byte presented to the sender; stable from LOAD through WAIT_DONE
//  byte_strobe  out  1               start pulse to the sender
//  byte_busy    in   1               sender busy; synchronised internally with 2 flops
//  frame_active out  1               high from accept until frame end or abort
//  frame_done   out  1               1-cycle pulse after the last byte completes
//  timeout_err  out  1               sticky; set on any busy timeout; cleared by the next accept
// BEHAVIOUR
//  Clock and reset: reset is asynchronous, active-high; clock is clk.
//  Reset values: state=IDLE, meas_ready=0 during reset and 1 from the first IDLE cycle, byte_data=0,
//   byte_strobe=0, frame_active=0, frame_done=0, timeout_err=0, byte index=0, timers=0.
//  Accept: meas_valid&&meas_ready at a rising edge latches meas_data into a shadow register.
//   The same edge clears timeout_err and enters LOAD. meas_data is ignored outside IDLE (no queuing).
//  Byte index idx: 0=HEADER; 1..DATA_BYTES=payload; DATA_BYTES+1=checksum (only with CHECKSUM_EN).
//  States:
//   IDLE      : meas_ready=1; on accept -> LOAD.
//   LOAD      : byte_data <= byte[idx]; -> STROBE (1 cycle).
//   STROBE    : byte_strobe=1 for STROBE_CYCLES cycles; -> WAIT_BUSY with timer=0.
//   WAIT_BUSY : wait for synced busy=1 -> WAIT_DONE, timer=0. Timer reaches BUSY_TIMEOUT -> ABORT.
//   WAIT_DONE : wait for synced busy=0 -> GAP. Timer reaches BUSY_TIMEOUT -> ABORT.
//   GAP       : count GAP_CYCLES. If idx == last, -> IDLE with frame_done=1 for 1 cycle; else idx++ -> LOAD.
//   ABORT     : timeout_err<=1, frame_active<=0, byte_strobe<=0, idx<=0; -> IDLE next cycle. No frame_done.
//  Latency: accept to first byte_strobe rise is 2 clk cycles.
//  Busy already high on entering WAIT_BUSY counts as the rise (no extra wait).
//  Busy falling while still in STROBE is ignored; only WAIT_* states sample busy.
//  Checksum: 8-bit XOR of the payload bytes only (HEADER excluded); computed from the shadow register.
//  Timers are 16-bit saturating; BUSY_TIMEOUT and GAP_CYCLES must be < 65535.
//  Reset mid-frame: returns to IDLE immediately; outputs take reset values; partial frame lost.
//  meas_valid held high continuously: a new frame is accepted on the first IDLE cycle after frame_done.
// CONFIGURATION
//  SPI_FRAME_CHECKSUM_EN defined  : frame = HEADER + DATA_BYTES + checksum (DATA_BYTES+2 bytes).
//  SPI_FRAME_CHECKSUM_EN undefined: frame = HEADER + DATA_BYTES (DATA_BYTES+1 bytes); no checksum logic.
// TESTING
//  1. Accept 32'h12345678; model busy as 4 cycles after strobe, 80 cycles long.
//     -> bytes A5,12,34,56,78 (+08 with CHECKSUM_EN); one frame_done pulse.
//  2. byte_busy tied 0 -> ABORT after BUSY_TIMEOUT cycles on the HEADER byte.
//     -> timeout_err=1, frame_active=0, no frame_done, meas_ready=1.
//  3. Assert reset mid-byte 3 -> all outputs at reset values.
//     -> next accept of 32'hDEADBEEF starts cleanly with A5.
//  4. meas_valid held high with alternating data -> back-to-back frames.
//     -> data sampled only at accept; gap between frames >= GAP_CYCLES.
//  5. byte_busy stuck 1 after the 2nd byte -> ABORT on the WAIT_DONE timeout.
//     -> timeout_err set; it clears on the next successful accept.
//  6. STROBE_CYCLES=3 -> byte_strobe high exactly 3 cycles per byte; byte_data stable over the whole strobe.

Source files
------------

// File: rtl/spi_frame_scheduler.sv
// Frames one measurement result as HEADER, payload bytes MSB-first and, with
// SPI_FRAME_CHECKSUM_EN defined, a trailing XOR checksum for the byte-level SPI sender.
module spi_frame_scheduler #(
  parameter int unsigned DATA_BYTES    = 4,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned BUSY_TIMEOUT  = 1023,
  parameter int unsigned GAP_CYCLES    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    meas_valid,
  input  logic [8*DATA_BYTES-1:0] meas_data,
  output logic                    meas_ready,
  output logic [7:0]              byte_data,
  output logic                    byte_strobe,
  input  logic                    byte_busy,
  output logic                    frame_active,
  output logic                    frame_done,
  output logic                    timeout_err
);

`ifdef SPI_FRAME_CHECKSUM_EN
  localparam int unsigned LAST_IDX = DATA_BYTES + 1;
`else
  localparam int unsigned LAST_IDX = DATA_BYTES;
`endif
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_T    = IDX_W'(LAST_IDX);
  localparam logic [15:0]      STROBE_T  = 16'(STROBE_CYCLES);
  localparam logic [15:0]      TIMEOUT_T = 16'(BUSY_TIMEOUT);
  localparam logic [15:0]      GAP_T     = 16'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STROBE, S_WAIT_BUSY, S_WAIT_DONE, S_GAP, S_ABORT
  } state_t;

  state_t                  state_q;
  logic [8*DATA_BYTES-1:0] shadow_q;
  logic [IDX_W-1:0]        idx_q;
  logic [15:0]             timer_q;
  logic                    meas_ready_q;
  logic [7:0]              byte_data_q;
  logic                    strobe_q;
  logic                    active_q;
  logic                    done_q;
  logic                    err_q;
  logic                    busy_meta_q;
  logic                    busy_sync_q;

  logic [15:0]             timer_inc_d;
  logic [7:0]              byte_sel_d;
  logic [7:0]              payload [DATA_BYTES];

  // payload[0] is the most significant byte, i.e. the first one on the wire
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
    assign payload[gi] = shadow_q[8*(DATA_BYTES-1-gi) +: 8];
  end

`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0] csum_d;
  always_comb begin
    csum_d = 8'h00;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      csum_d = csum_d ^ payload[i];
    end
  end
`endif

  always_comb begin
    byte_sel_d = HEADER;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      if (idx_q == IDX_W'(i + 1)) byte_sel_d = payload[i];
    end
`ifdef SPI_FRAME_CHECKSUM_EN
    if (idx_q == IDX_W'(DATA_BYTES + 1)) byte_sel_d = csum_d;
`endif
  end

  assign timer_inc_d = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_meta_q <= 1'b0;
      busy_sync_q <= 1'b0;
    end else begin
      busy_meta_q <= byte_busy;
      busy_sync_q <= busy_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shadow_q     <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      meas_ready_q <= 1'b0;
      byte_data_q  <= 8'h00;
      strobe_q     <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (meas_valid && meas_ready_q) begin
            shadow_q     <= meas_data;
            err_q        <= 1'b0;
            active_q     <= 1'b1;
            meas_ready_q <= 1'b0;
            idx_q        <= '0;
            state_q      <= S_LOAD;
          end else begin
            meas_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          byte_data_q <= byte_sel_d;
          timer_q     <= '0;
          state_q     <= S_STROBE;
        end
        S_STROBE: begin
          if (timer_q < STROBE_T) begin
            strobe_q <= 1'b1;
            timer_q  <= timer_inc_d;
          end else begin
            strobe_q <= 1'b0;
            timer_q  <= '0;
            state_q  <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (busy_sync_q) begin
            timer_q <= '0;
            state_q <= S_WAIT_DONE;
          end else if (timer_q >= TIMEOUT_T) begin
            state_q <= S_ABORT;
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        S_WAIT_DONE: begin
          if (!busy_sync_q) begin
            timer_q <= '0;
            state_q <= S_GAP;
          end else if (timer_q >= TIMEOUT_T) begin
            state_q <= S_ABORT;
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        S_GAP: begin
          if (timer_inc_d >= GAP_T) begin
            timer_q <= '0;
            if (idx_q == LAST_T) begin
              done_q       <= 1'b1;
              active_q     <= 1'b0;
              meas_ready_q <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_LOAD;
            end
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        S_ABORT: begin
          err_q        <= 1'b1;
          active_q     <= 1'b0;
          strobe_q     <= 1'b0;
          idx_q        <= '0;
          timer_q      <= '0;
          meas_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign meas_ready   = meas_ready_q;
  assign byte_data    = byte_data_q;
  assign byte_strobe  = strobe_q;
  assign frame_active = active_q;
  assign frame_done   = done_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Randomised bench for spi_frame_scheduler: a behavioural SPI sender drives byte_busy,
// and every frame seen on the byte interface is compared with a list built from the data.
module tb_spi_frame_scheduler;
  localparam int DB        = 4;
  localparam int STROBE_N  = 3;
  localparam int TIMEOUT_N = 200;
  localparam int GAP_N     = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            meas_valid;
  logic [8*DB-1:0] meas_data;
  logic            meas_ready;
  logic [7:0]      byte_data;
  logic            byte_strobe;
  logic            byte_busy;
  logic            frame_active;
  logic            frame_done;
  logic            timeout_err;

  always #5 clk = ~clk;

  spi_frame_scheduler #(
    .DATA_BYTES(DB), .HEADER(8'hA5), .STROBE_CYCLES(STROBE_N),
    .BUSY_TIMEOUT(TIMEOUT_N), .GAP_CYCLES(GAP_N)
  ) dut (
    .clk(clk), .reset(reset), .meas_valid(meas_valid), .meas_data(meas_data),
    .meas_ready(meas_ready), .byte_data(byte_data), .byte_strobe(byte_strobe),
    .byte_busy(byte_busy), .frame_active(frame_active), .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // monitor state
  logic [7:0] got_q[$];
  int         width_q[$];
  logic [7:0] exp_q[$];
  bit         mon_in;
  int         mon_w;
  logic [7:0] mon_byte;
  int         unstable, done_cnt, rises, min_gap;

  // sender model: 0 normal, 1 never busy, 2 stuck busy from byte 2, 3 clear
  int snd_mode, snd_delay, snd_len, busy_wait, busy_left, fall_t;
  logic strobe_d1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (byte_strobe) begin
      if (!mon_in) begin
        mon_in = 1'b1; mon_w = 0; mon_byte = byte_data; rises++;
        if (fall_t >= 0 && (cyc - fall_t) < min_gap) min_gap = cyc - fall_t;
      end
      mon_w++;
      if (byte_data !== mon_byte) unstable++;
    end else if (mon_in) begin
      mon_in = 1'b0;
      got_q.push_back(mon_byte);
      width_q.push_back(mon_w);
    end
    if (frame_done) done_cnt++;
    if (snd_mode == 3) begin
      byte_busy = 1'b0; busy_wait = 0; busy_left = 0; fall_t = -1;
    end else begin
      if (byte_strobe && !strobe_d1 && snd_mode != 1) begin
        busy_wait = snd_delay;
        busy_left = (snd_mode == 2 && rises >= 2) ? (1 << 30) : snd_len;
      end
      if (busy_wait > 0) begin
        busy_wait--;
        if (busy_wait == 0) byte_busy = 1'b1;
      end else if (byte_busy && busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin byte_busy = 1'b0; fall_t = cyc; end
      end
    end
    strobe_d1 = byte_strobe;
  endtask

  task automatic clear_mon();
    got_q.delete(); width_q.delete(); exp_q.delete();
    mon_in = 1'b0; unstable = 0; done_cnt = 0; rises = 0; min_gap = 1 << 30;
  endtask

  task automatic push_frame(input logic [8*DB-1:0] d);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = DB - 1; i >= 0; i--) begin
      b = d[8*i +: 8];
      x = x ^ b;
      exp_q.push_back(b);
    end
`ifdef SPI_FRAME_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic cmp_bytes(input string tag);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
      chk($sformatf("%s_w%0d", tag, i), width_q[i], STROBE_N);
    end
    chk({tag, "_stable"}, unstable, 0);
  endtask

  task automatic new_test(input int mode, input int delay, input int len);
    snd_mode = 3; step();
    snd_mode = mode; snd_delay = delay; snd_len = len;
    clear_mon();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!meas_ready && n < 100) begin step(); n++; end
    chk("ready_wait", meas_ready, 1'b1);
  endtask

  task automatic accept(input logic [8*DB-1:0] d);
    wait_ready();
    meas_valid = 1'b1; meas_data = d;
    step();
    meas_valid = 1'b0; meas_data = $urandom;
  endtask

  task automatic run_frame(input string tag, input logic [8*DB-1:0] d, input int delay, input int len);
    int n;
    new_test(0, delay, len);
    push_frame(d);
    accept(d);
    chk({tag, "_active"}, frame_active, 1'b1);
    chk({tag, "_ready_lo"}, meas_ready, 1'b0);
    chk({tag, "_err_clr"}, timeout_err, 1'b0);
    chk({tag, "_lat0"}, byte_strobe, 1'b0);
    step();
    chk({tag, "_lat1"}, byte_strobe, 1'b0);
    step();
    chk({tag, "_lat2"}, byte_strobe, 1'b1);
    n = 0;
    while (done_cnt == 0 && n < 20000) begin step(); n++; end
    step(); step();
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_idle_active"}, frame_active, 1'b0);
    chk({tag, "_idle_ready"}, meas_ready, 1'b1);
    chk({tag, "_gap"}, min_gap >= GAP_N, 1'b1);
    cmp_bytes(tag);
    $display("frame %s data=%h bytes=%0d done=%0d", tag, d, got_q.size(), done_cnt);
  endtask

  initial begin
    logic [8*DB-1:0] a, b;
    int n, t0, accepts;
    bit alt;
    reset = 1'b1; meas_valid = 1'b0; meas_data = '0; byte_busy = 1'b0;
    strobe_d1 = 1'b0; snd_mode = 3; snd_delay = 4; snd_len = 80; fall_t = -1;
    clear_mon();
    step(); step();
    chk("rst_ready", meas_ready, 1'b0);
    chk("rst_data", byte_data, 8'h00);
    chk("rst_strobe", byte_strobe, 1'b0);
    chk("rst_active", frame_active, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    reset = 1'b0;
    step(); step();
    chk("post_rst_ready", meas_ready, 1'b1);

    run_frame("basic", 32'h12345678, 4, 80);

    // sender never answers: header byte times out
    new_test(1, 4, 80);
    accept($urandom);
    t0 = cyc; n = 0;
    while (!timeout_err && n < 5000) begin step(); n++; end
    chk("to_lat_lo", (cyc - t0) >= TIMEOUT_N, 1'b1);
    chk("to_lat_hi", (cyc - t0) <= TIMEOUT_N + STROBE_N + 10, 1'b1);
    step();
    chk("to_err", timeout_err, 1'b1);
    chk("to_active", frame_active, 1'b0);
    chk("to_ready", meas_ready, 1'b1);
    chk("to_done", done_cnt, 0);
    chk("to_nbytes", got_q.size(), 1);
    $display("frame busy_dead bytes=%0d err=%0b", got_q.size(), timeout_err);

    // reset in the middle of the third byte
    new_test(0, 4, 80);
    accept(32'h12345678);
    n = 0;
    while (rises < 3 && n < 5000) begin step(); n++; end
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_ready", meas_ready, 1'b0);
    chk("mid_rst_data", byte_data, 8'h00);
    chk("mid_rst_strobe", byte_strobe, 1'b0);
    chk("mid_rst_active", frame_active, 1'b0);
    chk("mid_rst_done", frame_done, 1'b0);
    chk("mid_rst_err", timeout_err, 1'b0);
    reset = 1'b0;
    $display("frame reset_mid bytes_before=%0d", rises);
    run_frame("after_rst", 32'hDEADBEEF, 4, 80);

    // back-to-back frames with meas_valid held and data toggling every cycle
    new_test(0, 3, 20);
    a = $urandom; b = a ^ 32'hA5C3_3C5A;
    wait_ready();
    meas_valid = 1'b1; meas_data = a; push_frame(a); accepts = 1; alt = 1'b0;
    n = 0;
    while (n < 30000) begin
      step(); n++;
      if (done_cnt >= 3) break;
      alt = !alt;
      meas_data = alt ? b : a;
      if (meas_ready) begin push_frame(meas_data); accepts++; end
    end
    meas_valid = 1'b0;
    step(); step();
    chk("b2b_accepts", accepts, 3);
    chk("b2b_done", done_cnt, 3);
    chk("b2b_gap", min_gap >= GAP_N, 1'b1);
    chk("b2b_active", frame_active, 1'b0);
    cmp_bytes("b2b");
    $display("frame b2b frames=%0d bytes=%0d", done_cnt, got_q.size());

    // busy stuck high from the second byte on
    new_test(2, 3, 20);
    accept($urandom);
    n = 0;
    while (!timeout_err && n < 5000) begin step(); n++; end
    step();
    chk("stuck_err", timeout_err, 1'b1);
    chk("stuck_nbytes", got_q.size(), 2);
    chk("stuck_done", done_cnt, 0);
    chk("stuck_active", frame_active, 1'b0);
    chk("stuck_ready", meas_ready, 1'b1);
    $display("frame busy_stuck bytes=%0d err=%0b", got_q.size(), timeout_err);
    run_frame("err_clear", $urandom, 5, 30);

    for (int k = 0; k < 3; k++) begin
      run_frame($sformatf("rand%0d", k), $urandom, $urandom_range(1, 6), $urandom_range(8, 60));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
